// File: rtl/boot_loader_if.sv
// Word-addressed, byte-enabled synchronous memory port shared by the core and the RAM.
// The master drives address, write data and byte enables; the slave returns read data.
interface boot_loader_if #(
  parameter int unsigned M_WIDTH = 32
);
  logic [M_WIDTH-3:0]   addr;
  logic [M_WIDTH-1:0]   data_out;
  logic [M_WIDTH/8-1:0] wes;
  logic [M_WIDTH-1:0]   data_in;

  modport master (output addr, output data_out, output wes, input data_in);
  modport slave  (input addr, input data_out, input wes, output data_in);
endinterface

// File: rtl/boot_loader.sv
// UART boot loader: holds the core in reset, writes a framed serial payload into RAM
// from byte address 0, then releases the core and passes its memory port straight through.
module boot_loader #(
  parameter int unsigned M_WIDTH      = 32,
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned MAX_BYTES    = 4096,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx,
  boot_loader_if.slave  core,
  boot_loader_if.master mem,
  output logic         core_rst,
  output logic         loaded,
  output logic         error
);

  localparam int unsigned A_W    = M_WIDTH - 2;
  localparam int unsigned WES_W  = M_WIDTH / 8;
  localparam int unsigned LEN_W  = 32;
  localparam int unsigned CNT_W  = M_WIDTH;
  localparam int unsigned BIT_CW = $clog2(CLKS_PER_BIT);
  localparam logic [BIT_CW-1:0] FULL_CNT = BIT_CW'(CLKS_PER_BIT - 1);
  localparam logic [BIT_CW-1:0] HALF_CNT = BIT_CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {U_IDLE, U_START, U_DATA, U_STOP} uart_state_t;
  typedef enum logic [1:0] {L_SYNC, L_LEN, L_DATA, L_RUN} load_state_t;

  // rx synchronizer plus one delay stage for start-edge detection
  logic rx_m, rx_s, rx_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
      rx_d <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
      rx_d <= rx_s;
    end
  end

  uart_state_t       u_state_q, u_state_d;
  logic [BIT_CW-1:0] bit_cnt_q, bit_cnt_d;
  logic [2:0]        bit_idx_q, bit_idx_d;
  logic [7:0]        shift_q, shift_d;
  logic              byte_valid_q, byte_valid_d;
  logic              frame_err_q, frame_err_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      u_state_q    <= U_IDLE;
      bit_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      u_state_q    <= u_state_d;
      bit_cnt_q    <= bit_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
    end
  end

  // Start qualified at half a bit, then every sample one full bit later
  always_comb begin
    u_state_d    = u_state_q;
    bit_cnt_d    = bit_cnt_q;
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    case (u_state_q)
      U_IDLE: begin
        if (rx_d && !rx_s) begin
          u_state_d = U_START;
          bit_cnt_d = '0;
        end
      end
      U_START: begin
        if (bit_cnt_q == HALF_CNT) begin
          bit_cnt_d = '0;
          bit_idx_d = '0;
          u_state_d = rx_s ? U_IDLE : U_DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CW'(1);
        end
      end
      U_DATA: begin
        if (bit_cnt_q == FULL_CNT) begin
          bit_cnt_d = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          if (bit_idx_q == 3'd7) begin
            u_state_d = U_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CW'(1);
        end
      end
      U_STOP: begin
        if (bit_cnt_q == FULL_CNT) begin
          bit_cnt_d    = '0;
          u_state_d    = U_IDLE;
          byte_valid_d = rx_s;
          frame_err_d  = !rx_s;
        end else begin
          bit_cnt_d = bit_cnt_q + BIT_CW'(1);
        end
      end
      default: u_state_d = U_IDLE;
    endcase
  end

  load_state_t      state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic             error_q, error_d;
  logic             core_rst_q;
  logic [A_W-1:0]   addr_q;
  logic [M_WIDTH-1:0] dout_q;
  logic             wr_c;
  logic [LEN_W-1:0] len_shift;
  logic [CNT_W-1:0] cnt_inc;
  logic [A_W-1:0]   wr_addr;
  logic [WES_W-1:0] wr_wes;
  logic [M_WIDTH-1:0] wr_data;

  assign len_shift = {shift_q, len_q[LEN_W-1:8]};
  assign cnt_inc   = byte_cnt_q + CNT_W'(1);
  assign wr_addr   = byte_cnt_q[CNT_W-1:2];
  assign wr_wes    = WES_W'(1) << byte_cnt_q[1:0];
  assign wr_data   = {WES_W{shift_q}};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= L_SYNC;
      len_q      <= '0;
      byte_cnt_q <= '0;
      error_q    <= 1'b0;
      core_rst_q <= 1'b1;
      addr_q     <= '0;
      dout_q     <= '0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      byte_cnt_q <= byte_cnt_d;
      error_q    <= error_d;
      core_rst_q <= (state_q != L_RUN);
      if (wr_c) begin
        addr_q <= wr_addr;
        dout_q <= wr_data;
      end
    end
  end

  // Frame: SYNC_BYTE, 4-byte little-endian length, payload
  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    byte_cnt_d = byte_cnt_q;
    error_d    = error_q;
    wr_c       = 1'b0;
    case (state_q)
      L_SYNC: begin
        if (byte_valid_q && shift_q == SYNC_BYTE) begin
          state_d    = L_LEN;
          error_d    = 1'b0;
          byte_cnt_d = '0;
          len_d      = '0;
        end
      end
      L_LEN: begin
        if (frame_err_q) begin
          state_d    = L_SYNC;
          error_d    = 1'b1;
          byte_cnt_d = '0;
        end else if (byte_valid_q) begin
          len_d = len_shift;
          if (byte_cnt_q[1:0] == 2'd3) begin
            byte_cnt_d = '0;
            if (len_shift == '0) begin
              state_d = L_RUN;
            end else if (len_shift > LEN_W'(MAX_BYTES)) begin
              state_d = L_SYNC;
              error_d = 1'b1;
            end else begin
              state_d = L_DATA;
            end
          end else begin
            byte_cnt_d = cnt_inc;
          end
        end
      end
      L_DATA: begin
        if (frame_err_q) begin
          state_d    = L_SYNC;
          error_d    = 1'b1;
          byte_cnt_d = '0;
        end else if (byte_valid_q) begin
          wr_c       = 1'b1;
          byte_cnt_d = cnt_inc;
          if (cnt_inc == CNT_W'(len_q)) begin
            state_d = L_RUN;
          end
        end
      end
      L_RUN: state_d = L_RUN;
      default: state_d = L_SYNC;
    endcase
  end

  // Loader owns the RAM port until RUN, then the core drives it directly
  always_comb begin
    mem.addr     = addr_q;
    mem.data_out = dout_q;
    mem.wes      = '0;
    if (state_q == L_RUN) begin
      mem.addr     = core.addr;
      mem.data_out = core.data_out;
      mem.wes      = core.wes;
    end else if (wr_c) begin
      mem.addr     = wr_addr;
      mem.data_out = wr_data;
      mem.wes      = wr_wes;
    end
  end

  assign core.data_in = mem.data_in;
  assign core_rst     = core_rst_q;
  assign loaded       = (state_q == L_RUN);
  assign error        = error_q;

endmodule
